psg_multi_mixer: RTL
====================

// Module: psg_multi_mixer
// PURPOSE
//   Parametrised multi-chip PSG front end: decodes the chip-select write, routes BC to one of N_CHIPS
//   external YM2149 cores, muxes read-back data, tracks per-chip activity with hold timers and mixes the
//   active chips' A/B/C outputs into one normalised sample set. It sits between the CPU port decoder and the
//   audio DAC path. With N_CHIPS=2 its mix matches the existing dual-chip behaviour; it adds N-chip support,
//   mute, hold-based activity and registered outputs.
// PARAMETERS
//   N_CHIPS      2              number of PSG cores, legal 2..4
//   W            8              per-channel sample width in bits
//   HOLD         256            CE ticks a chip stays "playing" after its last non-zero sample, >=1
//   DEFAULT_SEL  N_CHIPS-1      chip selected after reset and always included in the mix
// PORTS
//   CLK        in   1          system clock
//   RESET_N    in   1          asynchronous reset, active low
//   CE         in   1          PSG clock enable; activity timers step only on CE
//   BDIR       in   1          bus direction (1 = write)
//   BC         in   1          bus control from port decoder
//   DI         in   8          CPU data
//   BC_OUT     out  N_CHIPS    per-chip BC, BC_OUT[i] = BC & (sel==i) (combinational)
//   DO_IN      in   8*N_CHIPS  chip read data, chip i at [8i+7:8i]
//   DO         out  8          DO_IN slice of selected chip (combinational)
//   CH_A_IN    in   W*N_CHIPS  chip channel A samples, chip i at [Wi+W-1:Wi]; CH_B_IN, CH_C_IN same
//   MUTE       in   N_CHIPS    1 = exclude chip from mix (activity tracking continues)
//   SEL_IDX    out  SB         current selection, SB = clog2(N_CHIPS)
//   PLAYING    out  N_CHIPS    per-chip activity flag (hold counter != 0)
//   CHANNEL_A  out  W          mixed channel A; CHANNEL_B, CHANNEL_C same
// BEHAVIOUR
//   Reset (RESET_N low, async): sel=DEFAULT_SEL, all hold counters 0, PLAYING=0, pipeline regs and
//     CHANNEL_A/B/C = 0. Reset mid-operation aborts the pipeline; first valid output 2 CLK after release.
//   Select: on CLK edge with BDIR&BC and DI[7:SB]=all ones: sel<=DI[SB-1:0] if < N_CHIPS, else unchanged.
//     The select write is still forwarded on BC_OUT of the old selection (same cycle, combinational).
//   Activity (per chip, on CE only): any of A/B/C non-zero -> counter<=HOLD; else if counter!=0 -> counter-1.
//     Counter width clog2(HOLD+1); no wrap below 0. Without CE counters hold.
//   Mix set: m[i] = (PLAYING[i] | i==DEFAULT_SEL) & ~MUTE[i]; n = popcount(m).
//   Stage 1 (every CLK): register masked samples (chip sample if m[i], else 0) and n.
//   Stage 2 (every CLK): sum in W+SB bits, zero-extended; shift s = 0 for n<=1, 1 for n=2, 2 for n=3..4;
//     CHANNEL_x <= sum >> s, truncated to W bits (never overflows: sum<=n*(2^W-1) < 2^(W+s)).
//   Latency: input sample / MUTE / PLAYING change -> CHANNEL_x in exactly 2 CLK.
//   n=0 (everything muted): outputs 0. Simultaneous select write and sample change: independent, no hazard.
// STRUCTURE
//   Package psg_pkg: SEL_PREFIX handling, shift LUT function mix_shift(n), clog2 helper, sample typedef.
//   Sub-module psg_activity_det (one per chip, generate loop): CE-gated hold counter + PLAYING output.
//   Top: select register, BC/DO routing, mask/popcount stage, adder/shift stage.
// TESTING
//   1 Reset, N=2: SEL_IDX=1, PLAYING=00, CHANNEL_*=0; only chip1 A=0x80 -> CHANNEL_A=0x80 after 2 CLK.
//   2 N=2, chip0 A=0x40, chip1 A=0x80, both active -> CHANNEL_A=0x60; BC_OUT follows sel after write DI=0xFE.
//   3 N=4, write DI=0xFD -> SEL_IDX=1; DI=0xFC->0; chips 0..3 A=0xFF all playing -> CHANNEL_A=0xFF (1020>>2).
//   4 HOLD=4: chip0 non-zero then zero; PLAYING[0] drops after exactly 4 CE ticks; no change without CE.
//   5 MUTE=all ones -> CHANNEL_*=0 after 2 CLK; clear MUTE[DEFAULT_SEL] -> default chip passed unscaled.
//   6 Assert RESET_N low mid-stream with sel=0 -> outputs 0 at once, sel=DEFAULT_SEL, counters cleared.

Source files
------------

// File: rtl/psg_pkg.sv
// psg_pkg: shared byte type, select-prefix decode, mix shift lookup and clog2 helper
package psg_pkg;
    typedef logic [7:0] bus_byte_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic sel_prefix_ok(input bus_byte_t di, input int sb);
        return (di >> sb) == (8'hff >> sb);
    endfunction

    function automatic logic [1:0] mix_shift(input logic [2:0] n);
        return n <= 3'd1 ? 2'd0 : n == 3'd2 ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/psg_activity_det.sv
// psg_activity_det: per-chip hold timer, keeps a chip playing for HOLD CE ticks after its last non-zero sample
module psg_activity_det import psg_pkg::*; #(
    parameter int HOLD = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic hit,
    output logic playing
);
    localparam int CW = clog2(HOLD + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (ce) cnt <= hit ? CW'(HOLD) : cnt - CW'(cnt != '0);
    assign playing = cnt != '0;
endmodule

// File: rtl/psg_multi_mixer.sv
// psg_multi_mixer: chip-select routing, read-back mux, activity tracking and two-stage normalised mix of N PSGs
module psg_multi_mixer import psg_pkg::*; #(
    parameter int N_CHIPS     = 2,
    parameter int W           = 8,
    parameter int HOLD        = 256,
    parameter int DEFAULT_SEL = N_CHIPS - 1
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        CE,
    input  logic                        BDIR,
    input  logic                        BC,
    input  logic [7:0]                  DI,
    output logic [N_CHIPS-1:0]          BC_OUT,
    input  logic [8*N_CHIPS-1:0]        DO_IN,
    output logic [7:0]                  DO,
    input  logic [W*N_CHIPS-1:0]        CH_A_IN,
    input  logic [W*N_CHIPS-1:0]        CH_B_IN,
    input  logic [W*N_CHIPS-1:0]        CH_C_IN,
    input  logic [N_CHIPS-1:0]          MUTE,
    output logic [clog2(N_CHIPS)-1:0]   SEL_IDX,
    output logic [N_CHIPS-1:0]          PLAYING,
    output logic [W-1:0]                CHANNEL_A,
    output logic [W-1:0]                CHANNEL_B,
    output logic [W-1:0]                CHANNEL_C
);
    localparam int SB = clog2(N_CHIPS);
    localparam int SW = W + SB;
    logic [SB-1:0] sel;
    logic [N_CHIPS-1:0] mix;
    logic [2:0] n_c, s1_n;
    logic [W*N_CHIPS-1:0] ch [3];
    logic [W-1:0] s1 [3][N_CHIPS];
    logic [SW-1:0] sum [3];
    assign ch = '{CH_A_IN, CH_B_IN, CH_C_IN};
    assign SEL_IDX = sel;
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) sel <= SB'(DEFAULT_SEL);
        else if (BDIR && BC && sel_prefix_ok(DI, SB) && int'(DI[SB-1:0]) < N_CHIPS) sel <= DI[SB-1:0];
    always_comb begin
        BC_OUT = '0;
        DO = '0;
        for (int i = 0; i < N_CHIPS; i++) begin
            BC_OUT[i] = BC && sel == SB'(i);
            if (sel == SB'(i)) DO = DO_IN[8*i +: 8];
        end
        mix = (PLAYING | (N_CHIPS'(1) << DEFAULT_SEL)) & ~MUTE;
        n_c = 3'($countones(mix));
    end
    for (genvar g = 0; g < N_CHIPS; g++) begin : g_act
        psg_activity_det #(.HOLD(HOLD)) u_det (
            .clk(CLK),
            .rst_n(RESET_N),
            .ce(CE),
            .hit(|{CH_A_IN[W*g +: W], CH_B_IN[W*g +: W], CH_C_IN[W*g +: W]}),
            .playing(PLAYING[g])
        );
    end
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < N_CHIPS; i++) s1[c][i] <= '0;
            s1_n <= '0;
        end else begin
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < N_CHIPS; i++) s1[c][i] <= mix[i] ? ch[c][W*i +: W] : '0;
            s1_n <= n_c;
        end
    always_comb
        for (int c = 0; c < 3; c++) begin
            sum[c] = '0;
            for (int i = 0; i < N_CHIPS; i++) sum[c] = sum[c] + SW'(s1[c][i]);
        end
    // sum never exceeds n*(2^W-1), so the shifted value always fits in W bits
    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            CHANNEL_A <= '0;
            CHANNEL_B <= '0;
            CHANNEL_C <= '0;
        end else begin
            CHANNEL_A <= W'(sum[0] >> mix_shift(s1_n));
            CHANNEL_B <= W'(sum[1] >> mix_shift(s1_n));
            CHANNEL_C <= W'(sum[2] >> mix_shift(s1_n));
        end
endmodule
